// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned MUL/MULHU/DIVU/REMU sequencer.
// Borrows the execute-stage 32-bit ALU for one add or subtract per cycle over
// 32 cycles. Shifting and bookkeeping live in local registers.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  input  logic        alu_c,
  input  logic        alu_u
);

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t              state;
  logic [4:0]          cnt;
  logic [1:0]          op_q;

  // Multiply working set: {hi,lo} is the running product, lo holds unconsumed multiplier bits.
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic [DATA_W-1:0]   mcand;

  // Divide working set: quo shifts the dividend out at the top and quotient bits in at the bottom.
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   dsor;

  logic                is_div;
  logic [DATA_W-1:0]   sh;
  logic                ge;
  logic [DATA_W-1:0]   hi_nx;
  logic [DATA_W-1:0]   lo_nx;
  logic [DATA_W-1:0]   rem_nx;
  logic [DATA_W-1:0]   quo_nx;

  // Pick the final value for the latched opcode from the post-iteration registers.
  function automatic logic [DATA_W-1:0] sel_result(
    input logic [1:0]        o,
    input logic [DATA_W-1:0] p_lo,
    input logic [DATA_W-1:0] p_hi,
    input logic [DATA_W-1:0] q,
    input logic [DATA_W-1:0] r
  );
    logic [DATA_W-1:0] v;
    case (o)
      OP_MUL:   v = p_lo;
      OP_MULHU: v = p_hi;
      OP_DIVU:  v = q;
      default:  v = r;
    endcase
    return v;
  endfunction

  assign is_div = op_q[1];
  assign sh     = {rem[DATA_W-2:0], quo[DATA_W-1]};
  // rem[31] set means the shifted partial remainder is 33 bits wide and
  // certainly exceeds the divisor; the 32-bit subtract is still exact then.
  assign ge     = rem[DATA_W-1] | ~alu_u;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  // ALU operand mux, driven only from registered state so the ALU path stays single-cycle.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    if (state == S_RUN) begin
      if (is_div) begin
        alu_a    = sh;
        alu_b    = dsor;
        alu_ctrl = ALU_SUB;
      end else begin
        alu_a    = hi;
        alu_b    = mcand;
        alu_ctrl = ALU_ADD;
      end
    end
  end

  // Per-iteration next values for both algorithms, fed by the shared ALU result.
  always_comb begin
    if (lo[0]) begin
      hi_nx = {alu_c, alu_out[DATA_W-1:1]};
      lo_nx = {alu_out[0], lo[DATA_W-1:1]};
    end else begin
      hi_nx = {1'b0, hi[DATA_W-1:1]};
      lo_nx = {hi[0], lo[DATA_W-1:1]};
    end
    rem_nx = ge ? alu_out : sh;
    quo_nx = {quo[DATA_W-2:0], ge};
  end

  // Sequencer FSM: accept a request, iterate 32 times, pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            cnt   <= '0;
            hi    <= '0;
            lo    <= src_b;
            mcand <= src_a;
            rem   <= '0;
            quo   <= src_a;
            dsor  <= src_b;
            if (op[1] && (src_b == '0)) begin
              state  <= S_DONE;
              result <= op[0] ? src_a : '1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            rem <= rem_nx;
            quo <= quo_nx;
          end else begin
            hi <= hi_nx;
            lo <= lo_nx;
          end
          if (cnt == 5'd31) begin
            state  <= S_DONE;
            result <= sel_result(op_q, lo_nx, hi_nx, quo_nx, rem_nx);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: plain-arithmetic reference model with a per-cycle
// compare process, directed literal cases and randomized operations.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_c;
  logic        alu_u;
  logic [32:0] sum33;

  int checks;
  int failures;
  bit chk_en;

  // reference model state
  bit          m_busy;
  bit          m_done;
  int          m_left;
  logic [31:0] m_result;
  logic [31:0] m_pend;
  logic [1:0]  m_op;

  muldiv_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .alu_c    (alu_c),
    .alu_u    (alu_u)
  );

  // the core ALU the sequencer borrows
  assign sum33   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out = (alu_ctrl == 4'b0001) ? (alu_a - alu_b) : sum33[31:0];
  assign alu_c   = sum33[32];
  assign alu_u   = (alu_a < alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_calc(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] v;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      2'b00:   v = p[31:0];
      2'b01:   v = p[63:32];
      2'b10:   v = (b == 32'd0) ? 32'hFFFFFFFF : (a / b);
      default: v = (b == 32'd0) ? a : (a % b);
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // cycle-level model: 32 edges of work after the accepting edge, then one done cycle
  always @(posedge clk) begin
    if (reset) begin
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_left   = 0;
      m_result = 32'd0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done   = 1'b1;
        m_result = m_pend;
      end
    end else if (start) begin
      m_pend = ref_calc(op, src_a, src_b);
      m_op   = op;
      m_busy = 1'b1;
      if (op[1] && (src_b == 32'd0)) begin
        m_done   = 1'b1;
        m_result = m_pend;
      end else begin
        m_left = 32;
      end
    end
  end

  // compare process on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("result", result, m_result);
      if (!m_busy) begin
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_b", alu_b, 32'd0);
        chk("idle_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      end else if (!m_done) begin
        chk("run_alu_ctrl", {28'd0, alu_ctrl}, {31'd0, m_op[1]});
      end
    end
  end

  // Issue one operation, optionally pulse a stray start at iteration inj,
  // then check latency, busy length and result against literal expectations.
  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int inj);
    int n;
    int bc;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    n  = 0;
    bc = busy ? 1 : 0;
    while (!done && n < 40) begin
      if (n == inj) begin
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'd3;
        src_b = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (busy) bc++;
    end
    start = 1'b0;
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no done within 40 cycles", nm);
    end else begin
      chk({nm, "_lat"}, n, exp_lat);
      chk({nm, "_busy_cycles"}, bc, exp_lat + 1);
      chk({nm, "_result"}, result, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    src_a    = 32'd0;
    src_b    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_op("mul_7x6",       2'b00, 32'd7, 32'd6, 32'd42, 32, -1);
    do_op("mulhu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, -1);
    do_op("divu_100_7",    2'b10, 32'd100, 32'd7, 32'd14, 32, -1);
    do_op("remu_100_7",    2'b11, 32'd100, 32'd7, 32'd2, 32, -1);
    do_op("divu_33bit",    2'b10, 32'hFFFFFFFF, 32'h80000001, 32'd1, 32, -1);
    do_op("remu_33bit",    2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32, -1);
    do_op("divu_by0",      2'b10, 32'd1234, 32'd0, 32'hFFFFFFFF, 0, -1);
    do_op("remu_by0",      2'b11, 32'd1234, 32'd0, 32'd1234, 0, -1);
    do_op("divu_stray_st", 2'b10, 32'd100, 32'd7, 32'd14, 32, 10);

    // reset in the middle of a multiply
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'd7;
    src_b = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    n = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    do_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15, 32, -1);

    // randomized operations checked against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = ra;
        default: rb = $urandom;
      endcase
      do_op("rand", ro, ra, rb, ref_calc(ro, ra, rb),
            (ro[1] && rb == 32'd0) ? 0 : 32, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
